// File: rtl/seg_link_rx.sv
// Receive side of the serial 7-segment link: synchronises a 74HC595-style stream,
// frames it on the latch edge and decodes each active-low segment pattern back to hex.
module seg_link_rx #(
    parameter int unsigned NUM_DIGITS  = 8,
    parameter int unsigned SEG_W       = 7,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                    CLOCK_50,
    input  logic                    KEY0,
    input  logic                    ser_clk,
    input  logic                    ser_data,
    input  logic                    ser_latch,
    output logic [4*NUM_DIGITS-1:0] digit_val,
    output logic [NUM_DIGITS-1:0]   digit_ok,
    output logic [NUM_DIGITS-1:0]   digit_blank,
    output logic                    frame_valid,
    output logic                    frame_err,
    output logic                    busy
);

    localparam int unsigned FRAME_W = NUM_DIGITS * SEG_W;
    localparam int unsigned VAL_W   = 4 * NUM_DIGITS;
    localparam int unsigned CNT_W   = 6;
    localparam int unsigned CNT_MAX = 63;
    localparam int unsigned IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SHIFT  = 2'd1,
        S_DECODE = 2'd2
    } state_e;

    logic [SYNC_STAGES-1:0] clk_sync_q, clk_sync_d;
    logic [SYNC_STAGES-1:0] data_sync_q, data_sync_d;
    logic [SYNC_STAGES-1:0] latch_sync_q, latch_sync_d;
    logic                   clk_prev_q, clk_prev_d;
    logic                   latch_prev_q, latch_prev_d;
    logic                   clk_rise, latch_rise, data_s;

    state_e                 state_q, state_d;
    logic [FRAME_W-1:0]     shift_q, shift_d, shift_upd;
    logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_upd;
    logic [FRAME_W-1:0]     hold_q, hold_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [VAL_W-1:0]       sh_val_q, sh_val_d;
    logic [NUM_DIGITS-1:0]  sh_ok_q, sh_ok_d;
    logic [NUM_DIGITS-1:0]  sh_blank_q, sh_blank_d;
    logic [VAL_W-1:0]       val_q, val_d;
    logic [NUM_DIGITS-1:0]  ok_q, ok_d;
    logic [NUM_DIGITS-1:0]  blank_q, blank_d;
    logic                   fv_q, fv_d;
    logic                   fe_q, fe_d;
    logic                   busy_q, busy_d;

    logic [SEG_W-1:0]       dec_pat;
    logic [3:0]             dec_val;
    logic                   dec_ok, dec_blank;

    // Input synchronisers and rising-edge detection on the last stage
    always_comb begin
        clk_sync_d   = SYNC_STAGES'({clk_sync_q, ser_clk});
        data_sync_d  = SYNC_STAGES'({data_sync_q, ser_data});
        latch_sync_d = SYNC_STAGES'({latch_sync_q, ser_latch});
        clk_prev_d   = clk_sync_q[SYNC_STAGES-1];
        latch_prev_d = latch_sync_q[SYNC_STAGES-1];
        clk_rise     = clk_sync_q[SYNC_STAGES-1] & ~clk_prev_q;
        latch_rise   = latch_sync_q[SYNC_STAGES-1] & ~latch_prev_q;
        data_s       = data_sync_q[SYNC_STAGES-1];
    end

    // Bit shifting happens in every state, ahead of latch evaluation
    always_comb begin
        shift_upd = shift_q;
        cnt_upd   = cnt_q;
        if (clk_rise) begin
            shift_upd = {shift_q[FRAME_W-2:0], data_s};
            if (cnt_q != CNT_W'(CNT_MAX)) begin
                cnt_upd = cnt_q + CNT_W'(1);
            end
        end
    end

    // Inverse of the hex_7seg table; {ok,val} packed per pattern
    always_comb begin
        dec_pat   = hold_q[32'(idx_q)*SEG_W +: SEG_W];
        dec_val   = 4'h0;
        dec_ok    = 1'b0;
        dec_blank = 1'b0;
        case (dec_pat)
            7'h40:   {dec_ok, dec_val} = 5'h10;
            7'h79:   {dec_ok, dec_val} = 5'h11;
            7'h24:   {dec_ok, dec_val} = 5'h12;
            7'h30:   {dec_ok, dec_val} = 5'h13;
            7'h19:   {dec_ok, dec_val} = 5'h14;
            7'h12:   {dec_ok, dec_val} = 5'h15;
            7'h02:   {dec_ok, dec_val} = 5'h16;
            7'h78:   {dec_ok, dec_val} = 5'h17;
            7'h00:   {dec_ok, dec_val} = 5'h18;
            7'h18:   {dec_ok, dec_val} = 5'h19;
            7'h08:   {dec_ok, dec_val} = 5'h1A;
            7'h46:   {dec_ok, dec_val} = 5'h1C;
            7'h06:   {dec_ok, dec_val} = 5'h1E;
            7'h0E:   {dec_ok, dec_val} = 5'h1F;
            7'h7F:   dec_blank = 1'b1;
            default: begin
                dec_val   = 4'h0;
                dec_ok    = 1'b0;
                dec_blank = 1'b0;
            end
        endcase
    end

    // Framing / decode FSM
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_upd;
        cnt_d      = cnt_upd;
        hold_d     = hold_q;
        idx_d      = idx_q;
        sh_val_d   = sh_val_q;
        sh_ok_d    = sh_ok_q;
        sh_blank_d = sh_blank_q;
        val_d      = val_q;
        ok_d       = ok_q;
        blank_d    = blank_q;
        fv_d       = 1'b0;
        fe_d       = 1'b0;

        case (state_q)
            S_IDLE, S_SHIFT: begin
                if (clk_rise) begin
                    state_d = S_SHIFT;
                end
                if (latch_rise) begin
                    cnt_d = '0;
                    if (cnt_upd == CNT_W'(FRAME_W)) begin
                        hold_d  = shift_upd;
                        idx_d   = '0;
                        state_d = S_DECODE;
                    end else begin
                        fe_d    = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            S_DECODE: begin
                // A new frame arriving mid-decode is dropped
                if (latch_rise) begin
                    fe_d  = 1'b1;
                    cnt_d = '0;
                end
                sh_val_d[32'(idx_q)*4 +: 4] = dec_val;
                sh_ok_d[idx_q]              = dec_ok;
                sh_blank_d[idx_q]           = dec_blank;
                if (idx_q == IDX_W'(NUM_DIGITS-1)) begin
                    val_d   = sh_val_d;
                    ok_d    = sh_ok_d;
                    blank_d = sh_blank_d;
                    fv_d    = 1'b1;
                    idx_d   = '0;
                    state_d = (cnt_d != '0) ? S_SHIFT : S_IDLE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d == S_DECODE);
    end

    always_ff @(posedge CLOCK_50 or negedge KEY0) begin
        if (!KEY0) begin
            clk_sync_q   <= '0;
            data_sync_q  <= '0;
            latch_sync_q <= '0;
            clk_prev_q   <= 1'b0;
            latch_prev_q <= 1'b0;
            state_q      <= S_IDLE;
            shift_q      <= '0;
            cnt_q        <= '0;
            hold_q       <= '0;
            idx_q        <= '0;
            sh_val_q     <= '0;
            sh_ok_q      <= '0;
            sh_blank_q   <= '0;
            val_q        <= '0;
            ok_q         <= '0;
            blank_q      <= '0;
            fv_q         <= 1'b0;
            fe_q         <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            clk_sync_q   <= clk_sync_d;
            data_sync_q  <= data_sync_d;
            latch_sync_q <= latch_sync_d;
            clk_prev_q   <= clk_prev_d;
            latch_prev_q <= latch_prev_d;
            state_q      <= state_d;
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            hold_q       <= hold_d;
            idx_q        <= idx_d;
            sh_val_q     <= sh_val_d;
            sh_ok_q      <= sh_ok_d;
            sh_blank_q   <= sh_blank_d;
            val_q        <= val_d;
            ok_q         <= ok_d;
            blank_q      <= blank_d;
            fv_q         <= fv_d;
            fe_q         <= fe_d;
            busy_q       <= busy_d;
        end
    end

    assign digit_val   = val_q;
    assign digit_ok    = ok_q;
    assign digit_blank = blank_q;
    assign frame_valid = fv_q;
    assign frame_err   = fe_q;
    assign busy        = busy_q;

endmodule
